// File: rtl/pwm_capture_if.sv
// pwm_capture_if: control inputs and measurement results of the PWM capture block
interface pwm_capture_if;
    logic        en;
    logic [31:0] timeout;
    logic        pwm_in;
    logic [31:0] period;
    logic [31:0] duty_cycle;
    logic        valid;
    logic        stalled;
    logic        stuck_level;

    modport master (
        output en, timeout, pwm_in,
        input  period, duty_cycle, valid, stalled, stuck_level
    );

    modport slave (
        input  en, timeout, pwm_in,
        output period, duty_cycle, valid, stalled, stuck_level
    );
endinterface

// File: rtl/pwm_capture.sv
// pwm_capture: measures PWM period/high time rise-to-rise with stall detection; PWM_CAPTURE_DEGLITCH_EN adds an input deglitch filter
module pwm_capture #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEGLITCH_CYCLES = 4
) (
    input logic          clk,
    input logic          rst,
    pwm_capture_if.slave bus
);
    typedef enum logic [1:0] {SEEK, HIGH, LOW, STALL} state_t;

    localparam logic [31:0] MAX = '1;

    state_t                 state, state_n;
    logic [SYNC_STAGES-1:0] sync;
    logic                   s, s_d, rise, fall, stall_hit, clr;
    logic [31:0]            per_cnt, hi_cnt, idle_cnt;

    if (SYNC_STAGES < 2 || DEGLITCH_CYCLES < 1) begin : g_bad_param
        $error("pwm_capture: SYNC_STAGES must be >= 2 and DEGLITCH_CYCLES >= 1");
    end

    function automatic logic [31:0] inc(input logic [31:0] v);
        return (v == MAX) ? v : v + 32'd1;
    endfunction

    // synchronizer chain; only rst clears it so en=0 keeps tracking the line
    always_ff @(posedge clk)
        sync <= rst ? '0 : {sync[SYNC_STAGES-2:0], bus.pwm_in};

`ifdef PWM_CAPTURE_DEGLITCH_EN
    localparam int CW = $clog2(DEGLITCH_CYCLES + 1);

    logic [CW-1:0] run;
    logic          filt;

    // filt follows the synchronized line only after it has disagreed for DEGLITCH_CYCLES cycles in a row
    always_ff @(posedge clk)
        if (rst) begin
            filt <= 1'b0;
            run  <= '0;
        end else if (sync[SYNC_STAGES-1] == filt) begin
            run <= '0;
        end else if (run == CW'(DEGLITCH_CYCLES - 1)) begin
            filt <= sync[SYNC_STAGES-1];
            run  <= '0;
        end else begin
            run <= run + 1'b1;
        end

    assign s = filt;
`else
    assign s = sync[SYNC_STAGES-1];
`endif

    // edge history runs with the synchronizer so re-enabling never invents an edge
    always_ff @(posedge clk)
        s_d <= rst ? 1'b0 : s;

    assign rise      = s & ~s_d;
    assign fall      = ~s & s_d;
    assign clr       = rst | ~bus.en;
    assign stall_hit = (bus.timeout != 32'd0) && (idle_cnt == bus.timeout) && !rise && !fall;

    // state register
    always_ff @(posedge clk)
        state <= clr ? SEEK : state_n;

    // next state: an edge always beats a timeout hit
    always_comb begin
        state_n = state;
        case (state)
            SEEK:    state_n = rise ? HIGH : stall_hit ? STALL : SEEK;
            HIGH:    state_n = fall ? LOW  : stall_hit ? STALL : HIGH;
            LOW:     state_n = rise ? HIGH : stall_hit ? STALL : LOW;
            default: state_n = rise ? HIGH : fall ? SEEK : STALL;
        endcase
    end

    // counters and published results
    always_ff @(posedge clk)
        if (clr) begin
            per_cnt         <= '0;
            hi_cnt          <= '0;
            idle_cnt        <= '0;
            bus.period      <= '0;
            bus.duty_cycle  <= '0;
            bus.valid       <= 1'b0;
            bus.stalled     <= 1'b0;
            bus.stuck_level <= 1'b0;
        end else begin
            bus.valid <= 1'b0;
            idle_cnt  <= (rise | fall) ? '0 : inc(idle_cnt);
            if (state != STALL && stall_hit) begin
                bus.stalled     <= 1'b1;
                bus.stuck_level <= s;
                bus.period      <= '0;
                bus.duty_cycle  <= '0;
            end else if (rise) begin
                if (state == LOW) begin
                    bus.period     <= per_cnt;
                    bus.duty_cycle <= hi_cnt;
                    bus.valid      <= 1'b1;
                end
                if (state == STALL) bus.stalled <= 1'b0;
                per_cnt <= 32'd1;
                hi_cnt  <= 32'd1;
            end else if (state == STALL) begin
                if (fall) bus.stalled <= 1'b0;
            end else if (state == HIGH) begin
                per_cnt <= inc(per_cnt);
                if (!fall) hi_cnt <= inc(hi_cnt);
            end else if (state == LOW) begin
                per_cnt <= inc(per_cnt);
            end
        end
endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: random and directed PWM stimulus checked every cycle against a timestamp-based model
module tb_pwm_capture;
    localparam int SS = 2;
    localparam int DG = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   nv = 0;

    pwm_capture_if bus ();

    pwm_capture #(.SYNC_STAGES(SS), .DEGLITCH_CYCLES(DG)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // model state: synchronized-line history plus timestamps of accepted edges
    bit     sq [SS];
    bit     sd, filt;
    int     run;
    longint cyc = 0, t_idle0 = 0, t_rise = 0, t_fall = 0;
    bit     have_rise, have_fall, m_stalled;
    longint e_period, e_duty;
    bit     e_valid, e_stalled, e_stuck;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // reference model step at each edge, then compare DUT outputs just after it
    always @(posedge clk) begin
        bit s, raw, rise, fall, hit;
        longint idle;
        raw = sq[SS-1];
`ifdef PWM_CAPTURE_DEGLITCH_EN
        s = filt;
`else
        s = raw;
`endif
        rise = s && !sd;
        fall = !s && sd;
        idle = cyc - t_idle0;
        hit  = (bus.timeout != 0) && (idle == longint'(bus.timeout)) && !rise && !fall && !m_stalled;
        e_valid = 1'b0;
        if (rst || !bus.en) begin
            e_period = 0; e_duty = 0; e_stalled = 0; e_stuck = 0;
            have_rise = 0; have_fall = 0; m_stalled = 0;
            t_idle0 = cyc + 1;
        end else begin
            if (rise || fall) t_idle0 = cyc + 1;
            if (hit) begin
                m_stalled = 1; e_stalled = 1; e_stuck = s;
                e_period = 0; e_duty = 0; have_rise = 0;
            end else if (rise) begin
                if (have_rise && have_fall) begin
                    e_period = cyc - t_rise;
                    e_duty   = t_fall - t_rise;
                    e_valid  = 1'b1;
                end
                have_rise = 1; have_fall = 0; t_rise = cyc;
                m_stalled = 0; e_stalled = 0;
            end else if (fall) begin
                m_stalled = 0; e_stalled = 0;
                if (have_rise) begin
                    have_fall = 1; t_fall = cyc;
                end
            end
        end
        if (rst) begin
            for (int i = 0; i < SS; i++) sq[i] = 0;
            sd = 0; filt = 0; run = 0;
        end else begin
            sd = s;
            if (raw != filt) begin
                run++;
                if (run == DG) begin
                    filt = raw;
                    run = 0;
                end
            end else begin
                run = 0;
            end
            for (int i = SS - 1; i > 0; i--) sq[i] = sq[i-1];
            sq[0] = bus.pwm_in;
        end
        cyc++;
        #1;
        chk("period", bus.period, e_period);
        chk("duty_cycle", bus.duty_cycle, e_duty);
        chk("valid", bus.valid, e_valid);
        chk("stalled", bus.stalled, e_stalled);
        chk("stuck_level", bus.stuck_level, e_stuck);
        if (bus.valid) nv++;
    end

    task automatic drive(input bit lvl, input int n);
        bus.pwm_in = lvl;
        repeat (n) @(negedge clk);
    endtask

    task automatic seg(input int h, input int l);
        drive(1'b1, h);
        drive(1'b0, l);
    endtask

    task automatic en_pulse(input int n);
        bus.en = 1'b0;
        repeat (n) @(negedge clk);
        bus.en = 1'b1;
    endtask

    initial begin
        int nv0;
        bus.en = 1'b0;
        bus.timeout = 0;
        bus.pwm_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_period", bus.period, 0);
        chk("rst_valid", bus.valid, 0);
        chk("rst_stalled", bus.stalled, 0);
        rst = 1'b0;
        bus.en = 1'b1;

        repeat (6) seg(3, 7);
        chk("loop_period", bus.period, 10);
        chk("loop_duty", bus.duty_cycle, 3);
        chk("loop_model_period", e_period, 10);

        en_pulse(3);
        repeat (3) seg(7, 13);
        chk("duty7_period", bus.period, 20);
        chk("duty7_duty", bus.duty_cycle, 7);
        repeat (2) seg(2, 18);
        chk("duty2_period", bus.period, 20);
        chk("duty2_duty", bus.duty_cycle, 2);
        chk("duty2_model_duty", e_duty, 2);

        bus.timeout = 50;
        repeat (3) seg(5, 15);
        drive(1'b1, 200);
        chk("stall_flag", bus.stalled, 1);
        chk("stall_level", bus.stuck_level, 1);
        chk("stall_period", bus.period, 0);
        chk("stall_duty", bus.duty_cycle, 0);
        drive(1'b0, 10);
        chk("stall_exit", bus.stalled, 0);
        nv0 = nv;
        repeat (2) seg(5, 15);
        chk("post_stall_valids", nv - nv0, 1);
        chk("post_stall_period", bus.period, 20);
        chk("post_stall_duty", bus.duty_cycle, 5);

        bus.timeout = 0;
        drive(1'b0, 1000);
        chk("no_timeout_stalled", bus.stalled, 0);
        chk("hold_period", bus.period, 20);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst2_period", bus.period, 0);
        chk("rst2_duty", bus.duty_cycle, 0);
        chk("rst2_stalled", bus.stalled, 0);
        chk("rst2_stuck", bus.stuck_level, 0);

        seg(5, 15);
        drive(1'b1, 3);
        bus.en = 1'b0;
        drive(1'b1, 4);
        bus.en = 1'b1;
        nv0 = nv;
        drive(1'b1, 2);
        drive(1'b0, 15);
        repeat (2) seg(5, 15);
        chk("en_drop_valids", nv - nv0, 1);
        chk("en_drop_period", bus.period, 20);
        chk("en_drop_duty", bus.duty_cycle, 5);

`ifdef PWM_CAPTURE_DEGLITCH_EN
        en_pulse(2);
        repeat (4) begin
            drive(1'b1, 4);
            drive(1'b0, 2);
            drive(1'b1, 4);
            drive(1'b0, 10);
        end
        chk("deglitch_period", bus.period, 20);
        chk("deglitch_duty", bus.duty_cycle, 10);
`endif

        repeat (60) begin
            if ($urandom_range(0, 5) == 0)
                bus.timeout = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(8, 60);
            if ($urandom_range(0, 9) == 0) en_pulse($urandom_range(1, 5));
            if ($urandom_range(0, 7) == 0)
                drive($urandom_range(0, 1), $urandom_range(40, 90));
            else
                seg($urandom_range(1, 25), $urandom_range(1, 25));
        end
        drive(1'b0, 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
